input_port_rx: RTL and testbench

INPUT_PORT_RX -- requirements
Module: input_port_rx

---
 rtl/pld_noc_pkg.sv | 24 ++
 rtl/freespace_credit_gen.sv | 49 ++++
 rtl/input_port_rx.sv | 104 ++++++++++
 tb/tb_input_port_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pld_noc_pkg.sv
// Packet layout and sizing shared by the NoC input-port and output-port sides.
// Packet, MSB first: {valid, dst_leaf, dst_port, reserved, addr, payload}.
package pld_noc_pkg;

    localparam int PKT_PAYLOAD_W  = 64;
    localparam int PKT_ADDR_W     = 7;
    localparam int PKT_RSVD_W     = 15;
    localparam int PKT_PORT_W     = 4;
    localparam int PKT_LEAF_W     = 6;
    localparam int PKT_W          = 1 + PKT_LEAF_W + PKT_PORT_W + PKT_RSVD_W
                                    + PKT_ADDR_W + PKT_PAYLOAD_W;

    localparam int PKT_PAYLOAD_LSB = 0;
    localparam int PKT_ADDR_LSB    = PKT_PAYLOAD_LSB + PKT_PAYLOAD_W;

    // Slots the user must drain before one freespace credit goes back.
    localparam int FREESPACE_UPDATE_SIZE_DEF = 64;

    // Most credits that can ever be outstanding: the whole buffer's worth.
    function automatic int credit_max(input int addr_bits, input int update_size);
        return (2 ** addr_bits) / update_size;
    endfunction

endpackage

// File: rtl/freespace_credit_gen.sv
// Counts user handshakes and turns every FREESPACE_UPDATE_SIZE of them into
// one freespace credit, queued until the network acknowledges it.
module freespace_credit_gen
    import pld_noc_pkg::*;
#(
    parameter int NUM_ADDR_BITS         = PKT_ADDR_W,
    parameter int FREESPACE_UPDATE_SIZE = FREESPACE_UPDATE_SIZE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic handshake,
    input  logic credit_ack,
    output logic credit_req
);

    localparam int PEND_MAX = credit_max(NUM_ADDR_BITS, FREESPACE_UPDATE_SIZE);
    localparam int CW       = $clog2(FREESPACE_UPDATE_SIZE + 1);
    localparam int PW       = $clog2(PEND_MAX + 1);

    logic [CW-1:0] consumed;
    logic [PW-1:0] pending;
    logic          earn;
    logic          spend;

    assign earn       = handshake && (consumed == CW'(FREESPACE_UPDATE_SIZE - 1));
    assign spend      = credit_req && credit_ack;
    assign credit_req = (pending != '0);

    // Consumed-slot counter wraps on each earned credit.
    always_ff @(posedge clk) begin
        if (!rst_n)
            consumed <= '0;
        else if (earn)
            consumed <= '0;
        else if (handshake)
            consumed <= consumed + CW'(1);
    end

    // Pending credits: earn and spend in one cycle cancel; clamp at buffer depth.
    always_ff @(posedge clk) begin
        if (!rst_n)
            pending <= '0;
        else if (earn && !spend && pending != PW'(PEND_MAX))
            pending <= pending + PW'(1);
        else if (spend && !earn)
            pending <= pending - PW'(1);
    end

endmodule

// File: rtl/input_port_rx.sv
// NoC input-port receive buffer: packets land in an address-indexed slot
// array in any order and are drained to the user strictly in slot order.
module input_port_rx
    import pld_noc_pkg::*;
#(
    parameter int PACKET_BITS           = PKT_W,
    parameter int NUM_LEAF_BITS         = PKT_LEAF_W,
    parameter int NUM_PORT_BITS         = PKT_PORT_W,
    parameter int NUM_ADDR_BITS         = PKT_ADDR_W,
    parameter int PAYLOAD_BITS          = PKT_PAYLOAD_W,
    parameter int FREESPACE_UPDATE_SIZE = FREESPACE_UPDATE_SIZE_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PACKET_BITS-1:0]  internal_in,
    input  logic                    wr_en_sel,
    output logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user,
    output logic                    vld_interface2user,
    input  logic                    ack_user2interface,
    output logic                    credit_req,
    input  logic                    credit_ack,
    output logic                    overflow
);

    localparam int DEPTH     = 2 ** NUM_ADDR_BITS;
    localparam int ADDR_LSB  = PKT_PAYLOAD_LSB + PAYLOAD_BITS;
    localparam int ADDR_MSB  = ADDR_LSB + NUM_ADDR_BITS - 1;
    localparam int VALID_BIT = PACKET_BITS - 1;
    localparam int PORT_LSB  = VALID_BIT - NUM_LEAF_BITS - NUM_PORT_BITS;

    logic [PAYLOAD_BITS-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]         occ;
    logic [NUM_ADDR_BITS-1:0] rd_ptr;
    logic [NUM_ADDR_BITS-1:0] wr_addr;
    logic [PAYLOAD_BITS-1:0]  wr_data;
    logic                     wr_req;
    logic                     wr_ok;
    logic                     load;
    logic                     unused_route;

    // Routing and reserved fields were consumed upstream by the leaf decoder.
    assign unused_route = ^internal_in[VALID_BIT-1:ADDR_MSB+1];

    assign wr_addr = internal_in[ADDR_MSB:ADDR_LSB];
    assign wr_data = internal_in[PAYLOAD_BITS-1:0];
    assign wr_req  = internal_in[VALID_BIT] && wr_en_sel;
    // Occupancy is sampled before this cycle's updates, so a write and a read
    // can never target the same slot in one cycle.
    assign wr_ok   = wr_req && !occ[wr_addr];
    assign load    = (!vld_interface2user || ack_user2interface) && occ[rd_ptr];

    // Slot payload storage; contents are only meaningful while occupied.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok)
            mem[wr_addr] <= wr_data;
    end

    // Occupied bits: set by an accepted write, cleared when drained.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            if (load)
                occ[rd_ptr] <= 1'b0;
            if (wr_ok)
                occ[wr_addr] <= 1'b1;
        end
    end

    // Output register: refill from rd_ptr when free or acked, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr                   <= '0;
            vld_interface2user       <= 1'b0;
            dout_leaf_interface2user <= '0;
        end else if (load) begin
            dout_leaf_interface2user <= mem[rd_ptr];
            vld_interface2user       <= 1'b1;
            rd_ptr                   <= rd_ptr + NUM_ADDR_BITS'(1);
        end else if (ack_user2interface) begin
            vld_interface2user       <= 1'b0;
        end
    end

    // Sticky flag for a write that landed on a still-occupied slot.
    always_ff @(posedge clk) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (wr_req && occ[wr_addr])
            overflow <= 1'b1;
    end

    freespace_credit_gen #(
        .NUM_ADDR_BITS         (NUM_ADDR_BITS),
        .FREESPACE_UPDATE_SIZE (FREESPACE_UPDATE_SIZE)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .handshake  (vld_interface2user && ack_user2interface),
        .credit_ack (credit_ack),
        .credit_req (credit_req)
    );

endmodule

// File: tb/tb_input_port_rx.sv
// Directed bench for input_port_rx against a slot-array / credit-count model.
module tb_input_port_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [96:0] internal_in;
    logic        wr_en_sel;
    logic [63:0] dout;
    logic        vld;
    logic        ack;
    logic        credit_req;
    logic        credit_ack;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;
    bit coin_seen;

    input_port_rx dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .internal_in              (internal_in),
        .wr_en_sel                (wr_en_sel),
        .dout_leaf_interface2user (dout),
        .vld_interface2user       (vld),
        .ack_user2interface       (ack),
        .credit_req               (credit_req),
        .credit_ack               (credit_ack),
        .overflow                 (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: buffer of 128 slots, output register, credit count.
    logic [63:0] m_mem [128];
    bit          m_occ [128];
    int          m_rdp;
    bit          m_vld;
    logic [63:0] m_dout;
    bit          m_ovf;
    int          m_cons;
    int          m_pend;

    always @(posedge clk) begin : model
        bit hs, ld, wr, earn, spend;
        int a, c, p;
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) m_occ[i] <= 0;
            m_rdp <= 0; m_vld <= 0; m_dout <= '0; m_ovf <= 0;
            m_cons <= 0; m_pend <= 0;
        end else begin
            hs = m_vld && ack;
            ld = (!m_vld || ack) && m_occ[m_rdp];
            wr = internal_in[96] && wr_en_sel;
            a  = int'(internal_in[70:64]);
            if (wr) begin
                if (m_occ[a]) m_ovf <= 1;
                else begin m_occ[a] <= 1; m_mem[a] <= internal_in[63:0]; end
            end
            if (ld) begin
                m_dout <= m_mem[m_rdp]; m_vld <= 1; m_occ[m_rdp] <= 0;
                m_rdp <= (m_rdp + 1) % 128;
            end else if (ack) m_vld <= 0;
            c = m_cons + (hs ? 1 : 0);
            earn = (c == 64);
            m_cons <= earn ? 0 : c;
            spend = (m_pend > 0) && credit_ack;
            p = m_pend + (earn ? 1 : 0) - (spend ? 1 : 0);
            m_pend <= (p > 2) ? 2 : p;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock; outputs compared against the model 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (chk_en) begin
            chk("cyc_vld", vld, m_vld);
            chk("cyc_dout", dout, m_dout);
            chk("cyc_credit_req", credit_req, m_pend > 0);
            chk("cyc_overflow", overflow, m_ovf);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input int a, input logic [63:0] d, input bit v = 1, input bit sel = 1);
        logic [6:0] a7;
        a7 = a[6:0];
        internal_in = {v, 6'h2a, 4'h5, 15'h0, a7, d};
        wr_en_sel   = sel;
        tick();
        internal_in = '0;
        wr_en_sel   = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        ticks(2);
        rst_n = 1;
    endtask

    task automatic stream(input int n, input logic [63:0] dbase);
        int b;
        b = m_rdp;
        for (int i = 0; i < n; i++) wr((b + i) % 128, dbase + 64'(i));
        ticks(3);
    endtask

    initial begin
        rst_n = 0; internal_in = '0; wr_en_sel = 0; ack = 0; credit_ack = 0;
        tick();
        chk_en = 1;
        tick();
        rst_n = 1;
        chk("rst_vld", vld, 0);
        chk("rst_dout", dout, 0);
        chk("rst_credit_req", credit_req, 0);
        chk("rst_overflow", overflow, 0);

        // In-order writes 0..3, ack held: one payload per cycle, latency 1.
        ack = 1;
        wr(0, 64'hA0);
        chk("seq_first_vld", vld, 0);
        wr(1, 64'hA1);
        chk("seq_vld", vld, 1);
        chk("seq_dout0", dout, 64'hA0);
        wr(2, 64'hA2);
        chk("seq_dout1", dout, 64'hA1);
        wr(3, 64'hA3);
        chk("seq_dout2", dout, 64'hA2);
        tick();
        chk("seq_dout3", dout, 64'hA3);
        tick();
        chk("seq_idle_vld", vld, 0);
        // Invalid packet and unselected port are both ignored (rd_ptr now 4).
        wr(4, 64'hBAD, 0, 1);
        wr(4, 64'hBAD, 1, 0);
        ticks(2);
        chk("ignore_vld", vld, 0);

        // Out-of-order arrival 2,1,0 drains as 0,1,2.
        do_reset();
        wr(2, 64'hB2);
        wr(1, 64'hB1);
        chk("ooo_wait_vld", vld, 0);
        wr(0, 64'hB0);
        chk("ooo_land_vld", vld, 0);
        tick();
        chk("ooo_dout0", dout, 64'hB0);
        tick();
        chk("ooo_dout1", dout, 64'hB1);
        tick();
        chk("ooo_dout2", dout, 64'hB2);
        tick();
        chk("ooo_end_vld", vld, 0);

        // Backpressure freeze and overflow on an occupied slot.
        do_reset();
        ack = 0;
        for (int i = 0; i < 4; i++) wr(i, 64'hC0 + 64'(i));
        ticks(2);
        chk("bp_vld", vld, 1);
        chk("bp_dout", dout, 64'hC0);
        wr(1, 64'hDEAD);
        chk("ovf_flag", overflow, 1);
        chk("ovf_hold", dout, 64'hC0);
        ack = 1;
        tick();
        chk("ovf_keep_data", dout, 64'hC1);
        ticks(2);
        chk("ovf_last", dout, 64'hC3);
        tick();
        chk("ovf_sticky", overflow, 1);

        // 192 handshakes across the 127->0 wrap: credits saturate at 2.
        do_reset();
        stream(192, 64'h1000);
        chk("sat_credit_req", credit_req, 1);
        chk("model_pend_sat", 64'(m_pend), 2);
        credit_ack = 1; tick(); credit_ack = 0;
        chk("sat_one_ack", credit_req, 1);
        chk("model_pend_one", 64'(m_pend), 1);
        credit_ack = 1; tick(); credit_ack = 0;
        chk("sat_two_ack", credit_req, 0);

        // Earn a credit, then make the next earn coincide with an ack.
        stream(64, 64'h2000);
        chk("earn_credit_req", credit_req, 1);
        coin_seen = 0;
        begin
            int b;
            b = m_rdp;
            for (int i = 0; i < 67; i++) begin
                if (i < 64) begin
                    internal_in = {1'b1, 6'h2a, 4'h5, 15'h0, 7'((b + i) % 128), 64'h3000 + 64'(i)};
                    wr_en_sel = 1;
                end
                credit_ack = (m_cons == 63) && m_vld && ack;
                if (credit_ack) coin_seen = 1;
                tick();
                credit_ack = 0; internal_in = '0; wr_en_sel = 0;
            end
        end
        chk("coin_hit", 64'(coin_seen), 1);
        chk("coin_credit_req", credit_req, 1);
        chk("model_pend_coin", 64'(m_pend), 1);
        credit_ack = 1; tick(); credit_ack = 0;
        chk("coin_drained", credit_req, 0);

        // Reset mid-transfer with credits pending, 5 slots full, overflow set.
        stream(64, 64'h4000);
        ack = 0;
        begin
            int b;
            b = m_rdp;
            for (int i = 0; i < 6; i++) wr((b + i) % 128, 64'h5000 + 64'(i));
            wr((b + 3) % 128, 64'hBEEF);
        end
        chk("pre_rst_vld", vld, 1);
        chk("pre_rst_ovf", overflow, 1);
        chk("pre_rst_credit", credit_req, 1);
        rst_n = 0;
        internal_in = {1'b1, 6'h2a, 4'h5, 15'h0, 7'd0, 64'h6666};
        wr_en_sel = 1;
        tick();
        internal_in = '0; wr_en_sel = 0; rst_n = 1; ack = 1;
        chk("mid_rst_vld", vld, 0);
        chk("mid_rst_credit", credit_req, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_dout", dout, 0);
        ticks(4);
        chk("post_rst_empty", vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
